// File: rtl/step_accum_pdu.sv
// Board wrapper: switch words are latched on a synced valid edge and summed into
// an 8-bit accumulator on each step/run tick; internal state is scanned onto a hex digit bus.
module step_accum_pdu #(
    parameter int SCAN_DIV = 1
) (
    input  logic       clk,
    input  logic [7:0] sw,
    input  logic       button,
    output logic [2:0] an,
    output logic [3:0] seg,
    output logic [7:0] led
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic       rst_n, run, valid;
    logic [4:0] din;
    assign rst_n = sw[7];
    assign run   = sw[6];
    assign valid = sw[5];
    assign din   = sw[4:0];

    // [0],[1] synchroniser stages, [2] previous synced level for edge detect
    logic [2:0] btn_sync, vld_sync;
    logic       step_p, valid_p;
    logic       tick;

    logic [7:0] acc, cnt;
    logic [4:0] in_reg;
    logic       pend;

    logic [SW-1:0] scan_cnt;
    logic [31:0]   disp;

    assign tick = run | step_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_sync <= '0;
            vld_sync <= '0;
            step_p   <= 1'b0;
            valid_p  <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[1:0], button};
            vld_sync <= {vld_sync[1:0], valid};
            step_p   <= btn_sync[1] & ~btn_sync[2];
            valid_p  <= vld_sync[1] & ~vld_sync[2];
        end
    end

    // A new word landing on the same tick that consumes the old one keeps pend set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            in_reg <= '0;
            pend   <= 1'b0;
        end else begin
            if (tick && pend) begin
                acc  <= acc + {3'b000, in_reg};
                cnt  <= cnt + 8'd1;
                pend <= 1'b0;
            end
            if (valid_p) begin
                in_reg <= din;
                pend   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            an       <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            an       <= an + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign disp = {cnt, 3'b000, in_reg, 7'b0000000, pend, acc};
    assign seg  = disp[{an, 2'b00} +: 4];
    assign led  = acc;
endmodule

// File: tb/tb_step_accum_pdu.sv
// Directed bench for step_accum_pdu: reset, step/run accumulate, wrap, same-cycle
// latch+consume and display scan, against hand-computed values.
module tb_step_accum_pdu;
    logic       clk = 1'b0;
    logic [7:0] sw;
    logic       button;
    logic [2:0] an;
    logic [3:0] seg;
    logic [7:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    step_accum_pdu #(.SCAN_DIV(1)) dut (
        .clk(clk), .sw(sw), .button(button), .an(an), .seg(seg), .led(led)
    );

    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        sw = 8'h00;
        button = 1'b0;
        wait_cyc(3);
        sw[7] = 1'b1;
        wait_cyc(2);
    endtask

    task automatic press();
        button = 1'b1;
        wait_cyc(5);
        button = 1'b0;
        wait_cyc(5);
    endtask

    task automatic offer(input logic [4:0] d);
        sw[4:0] = d;
        sw[5] = 1'b1;
        wait_cyc(5);
        sw[5] = 1'b0;
        wait_cyc(5);
    endtask

    // Waits (bounded) until the scan reaches digit d and returns its nibble.
    task automatic read_digit(input logic [2:0] d, output logic [3:0] v, output bit ok);
        ok = 1'b0;
        v = 4'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an === d) begin
                v = seg;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] v;
        bit ok;
        sw = 8'h00;
        button = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            button = i[0];
            sw[5] = ~i[0];
            sw[4:0] = 5'd7;
            sw[6] = i[1];
        end
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h want 00", led); end
        n_checks++;
        if (an !== 3'd0) begin n_fail++; $display("FAIL reset_an got %0d want 0", an); end
        n_checks++;
        if (seg !== 4'h0) begin n_fail++; $display("FAIL reset_seg got %h want 0", seg); end
        // valid high across release: exactly one edge after release, latched word 4
        sw = 8'b1010_0100;
        button = 1'b0;
        wait_cyc(8);
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL reset_no_tick got %h want 00", led); end
        read_digit(3'd2, v, ok);
        n_checks++;
        if (!ok || v !== 4'h1) begin n_fail++; $display("FAIL reset_held_valid_pend got %h ok %0d want 1", v, ok); end
        press();
        n_checks++;
        if (led !== 8'h04) begin n_fail++; $display("FAIL reset_held_valid_acc got %h want 04", led); end
    endtask

    task automatic test_step();
        logic [3:0] v;
        bit ok;
        do_reset();
        sw[6] = 1'b0;
        offer(5'd1);
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL step_no_tick got %h want 00", led); end
        press();
        n_checks++;
        if (led !== 8'h01) begin n_fail++; $display("FAIL step_first got %h want 01", led); end
        read_digit(3'd6, v, ok);
        n_checks++;
        if (!ok || v !== 4'h1) begin n_fail++; $display("FAIL step_cnt got %h ok %0d want 1", v, ok); end
        press();
        n_checks++;
        if (led !== 8'h01) begin n_fail++; $display("FAIL step_second got %h want 01", led); end
        read_digit(3'd2, v, ok);
        n_checks++;
        if (!ok || v !== 4'h0) begin n_fail++; $display("FAIL step_pend_clear got %h ok %0d want 0", v, ok); end
    endtask

    task automatic test_run_and_scan();
        logic [31:0] d;
        logic [2:0]  prev;
        do_reset();
        sw[6] = 1'b1;
        offer(5'd5);
        n_checks++;
        if (led !== 8'h05) begin n_fail++; $display("FAIL run_first got %h want 05", led); end
        offer(5'd31);
        n_checks++;
        if (led !== 8'h24) begin n_fail++; $display("FAIL run_second got %h want 24", led); end
        // cnt=2, in_reg=31, pend=0, acc=0x24
        d = 32'h021F_0024;
        @(negedge clk);
        prev = an;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== prev + 3'd1) begin n_fail++; $display("FAIL scan_an got %0d want %0d", an, prev + 3'd1); end
            n_checks++;
            if (seg !== d[{an, 2'b00} +: 4]) begin
                n_fail++; $display("FAIL scan_seg an %0d got %h want %h", an, seg, d[{an, 2'b00} +: 4]);
            end
            prev = an;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] v;
        bit ok;
        do_reset();
        sw[6] = 1'b1;
        for (int i = 0; i < 9; i++) offer(5'd31);
        n_checks++;
        if (led !== 8'h17) begin n_fail++; $display("FAIL wrap_acc got %h want 17", led); end
        read_digit(3'd6, v, ok);
        n_checks++;
        if (!ok || v !== 4'h9) begin n_fail++; $display("FAIL wrap_cnt_lo got %h ok %0d want 9", v, ok); end
        read_digit(3'd7, v, ok);
        n_checks++;
        if (!ok || v !== 4'h0) begin n_fail++; $display("FAIL wrap_cnt_hi got %h ok %0d want 0", v, ok); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] v;
        bit ok;
        do_reset();
        sw[6] = 1'b0;
        offer(5'd2);
        // button and valid rise together: same sync depth gives same-cycle pulses
        sw[4:0] = 5'd3;
        sw[5] = 1'b1;
        button = 1'b1;
        wait_cyc(5);
        sw[5] = 1'b0;
        button = 1'b0;
        wait_cyc(5);
        n_checks++;
        if (led !== 8'h02) begin n_fail++; $display("FAIL simul_acc got %h want 02", led); end
        read_digit(3'd2, v, ok);
        n_checks++;
        if (!ok || v !== 4'h1) begin n_fail++; $display("FAIL simul_pend got %h ok %0d want 1", v, ok); end
        read_digit(3'd4, v, ok);
        n_checks++;
        if (!ok || v !== 4'h3) begin n_fail++; $display("FAIL simul_in_reg got %h ok %0d want 3", v, ok); end
        press();
        n_checks++;
        if (led !== 8'h05) begin n_fail++; $display("FAIL simul_consume got %h want 05", led); end
    endtask

    initial begin
        sw = 8'h00;
        button = 1'b0;
        test_reset();
        test_step();
        test_run_and_scan();
        test_wrap();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
